ifu_assoc: RTL and testbench
============================

# ifu_assoc

Parametrised instruction fetch unit with a set-associative instruction cache. It generates the next PC (sequential +4 or redirect), looks the PC up in a WAYS-way cache of LINE_BYTES-byte lines, and refills whole lines from the RAM instruction port on a miss. It adds invalidate-all (flush) and true two-way LRU replacement. It sits between the branch/stall controller and the ID stage and holds the stage's PC and instruction registers.

## Interface
- ADDR_W, 17, PC/fetch address width in bits
- LINE_BYTES, 16, cache line size in bytes; power of two, at least 4; line data width is LINE_BYTES*8
- SETS, 32, number of sets; power of two
- WAYS, 2, associativity; legal values are 1 and 2
- STALL_W, 5, width of the pipeline stall vector
- clk  in  1  the block's single clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; when low, every register holds
- stall  in  STALL_W  pipeline stall vector; bit 0 freezes IF
- use_npc  in  1  redirect request; select npc_addr over pc+4
- npc_addr  in  ADDR_W  redirect target
- flush  in  1  invalidate all cache lines (fence.i)
- ram_inst  in  LINE_BYTES*8  refill line data; valid in the cycle ram_inst_busy falls
- ram_inst_busy  in  1  RAM port busy fetching
- pc  out  ADDR_W  PC of the instruction in `inst`
- inst  out  32  fetched instruction; 0 is a bubble
- ram_inst_re  out  1  refill request
- ram_inst_addr  out  32  line-aligned refill address, zero-extended
- stall_req  out  1  stall request to the controller while a miss is pending
- hit_cnt  out  32  hit counter
- miss_cnt  out  32  miss counter

## Operation
- Address fields: offset = log2(LINE_BYTES) bits; index = log2(SETS) bits; tag = the remaining upper bits.
- Each way entry holds a valid bit, a tag and a line. Each set has one LRU bit, used only when WAYS=2.
- npc = use_npc ? npc_addr : pc + 4, computed modulo 2^ADDR_W.
- Hit: any valid way in set[index(npc)] has a matching tag. Word select is offset[..2].
- A hit sets the set's LRU bit to point at the other way.
- Refill victim: the first invalid way, way 0 first. If both ways are valid, the LRU way. After a refill, LRU points away from the filled way.
- Branch/load bubble: the instruction just delivered has opcode bit 6 set, or opcode[6:4]==000. The next slot is then a zero bubble. This matches the existing decode-hazard contract.
- States:
  - LOOKUP: if stall[0]=0, pc<=npc and ram_inst_addr<=line-aligned npc.
    - On a hit, inst<=the hit word and go to BUBBLE if it is a branch/load, else stay in LOOKUP.
    - On a miss, stall_req<=1, ram_inst_re<=1, inst<=0, go to REQ.
    - If stall[0]=1, inst and pc hold.
  - REQ: hold the request. Go to WAIT when ram_inst_busy=1.
  - WAIT: while busy, hold. When busy=0:
    - write the line, inst<=the selected word of ram_inst;
    - stall_req<=0, ram_inst_re<=0;
    - go to BUBBLE or LOOKUP by the same branch/load rule.
  - BUBBLE: inst<=0 unless stall[0]; stay in BUBBLE while stall[0]=1, else go to LOOKUP.
- Redirects (use_npc) are sampled only in LOOKUP with stall[0]=0. The controller holds use_npc until stall_req is low.
- Flush:
  - All valid bits and LRU bits clear at the next edge.
  - If flush arrives during REQ or WAIT, the pending refill still delivers its instruction but is not written into the cache. A sticky drop flag, cleared on entry to LOOKUP, records this.
  - Flush in the same cycle as a refill write: the flush wins and the line is not written.
- Reset (asynchronous, any state, including mid-refill):
  - state=LOOKUP, pc = all ones minus 3 (that is, -4), inst=0;
  - ram_inst_re=0, ram_inst_addr=32'hFFFFFFFF, stall_req=0;
  - all valid and LRU bits 0, counters 0.
  - A refill in flight at reset is abandoned.

## Timing
- Hit: the instruction appears on `inst`/`pc` one cycle after the LOOKUP edge.
- Miss: stall_req and ram_inst_re rise one cycle after the LOOKUP edge and stay high through REQ and WAIT.
  - They drop on the same edge that loads `inst` from ram_inst.
  - Minimum miss penalty = 1 + busy-rise wait + busy-high duration cycles.
- A line written at edge N hits for an LOOKUP at edge N+1 or later.
- Cache arrays need no reset beyond valid/LRU. Register or RAM inference is allowed if lookup stays combinational within the cycle.

## Configuration
- IFU_PERF_CNT_EN defined:
  - hit_cnt increments on each LOOKUP hit taken (stall[0]=0, rdy=1);
  - miss_cnt increments on each miss entering REQ;
  - both wrap at 2^32 and clear on reset.
- Not defined: hit_cnt and miss_cnt are tied to 0 and no counter flops exist.

## Structure
- Shared package (defines file): True_v/False_v, ZeroWord, state encodings (LOOKUP=2'b00, WAIT=2'b01, REQ=2'b10, BUBBLE=2'b11), and a branch/load opcode-test function.
- One natural sub-module: `icache_sa_array`. It holds tags, data, valid and LRU; provides combinational lookup (hit, way, word), a write port (index, way, tag, line), and flush.
- The FSM, PC logic and counters live in `ifu_assoc`.

## Test plan
- Reset, then 4 cycles with all lines invalid and RAM busy 3 cycles:
  - the first fetch at pc=0 misses;
  - ram_inst_addr=0 and stall_req=1 until busy falls;
  - inst = word 0 of the line.
- Sequential hits at 0x4, 0x8, 0xC after the refill: no stall_req, one instruction per cycle. An instruction with opcode 0x63 at 0x8 inserts one inst=0 bubble.
- WAYS=2, SETS=32, LINE_BYTES=16:
  - fetch 0x0000, 0x0200, then 0x0000 (LRU now points at the 0x0200 way), then 0x0400;
  - 0x0400 evicts 0x0200, and a later fetch of 0x0000 still hits.
- Flush pulsed during WAIT of a miss at 0x1000:
  - inst is delivered;
  - a refetch of 0x1000 misses again;
  - all previously cached lines miss.
- stall[0] held 3 cycles in LOOKUP with use_npc=1 and npc_addr=0x0100: pc and inst hold. After release, pc=0x0100.
- With IFU_PERF_CNT_EN: 1 miss + 3 hits gives hit_cnt=3, miss_cnt=1. Asserting rst mid-WAIT clears the counters, ram_inst_re and stall_req immediately.

Source files
------------

// File: rtl/ifu_assoc_pkg.sv
// ifu_assoc_pkg
// Shared definitions for the set-associative instruction fetch unit:
// boolean constants, the zero instruction word, the fetch FSM state
// encoding and the branch/load opcode test that decides when a bubble
// must follow a delivered instruction.
// Optional feature macro used by the top: IFU_PERF_CNT_EN.
package ifu_assoc_pkg;

  localparam logic        True_v   = 1'b1;
  localparam logic        False_v  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    LOOKUP = 2'b00,
    WAIT   = 2'b01,
    REQ    = 2'b10,
    BUBBLE = 2'b11
  } ifu_state_e;

  // Branches, jumps and loads (opcode bit 6 set, or opcode[6:4] == 000)
  // must be followed by a zero bubble so decode can resolve the hazard.
  function automatic logic is_branch_load(input logic [31:0] word);
    return word[6] || (word[6:4] == 3'b000);
  endfunction

endpackage

// File: rtl/icache_sa_array.sv
// icache_sa_array
// Tag/data/valid/LRU storage for a 1- or 2-way set-associative I-cache.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (valid/LRU only)
//   en            global enable; all state holds when low
//   flush         clear every valid and LRU bit at the next enabled edge
//   lookup_addr   address looked up combinationally -> hit, hit_way, hit_word
//   touch         on a hit, point the set's LRU bit at the other way
//   fill_addr     address of the line being refilled (index + tag)
//   fill_way      victim way for fill_addr's set
//   we, wr_way,   write port: store wr_line/tag into wr_way of fill_addr's set
//   wr_line
module icache_sa_array
  import ifu_assoc_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 32,
  parameter int WAYS       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       lookup_addr,
  output logic                    hit,
  output logic                    hit_way,
  output logic [31:0]             hit_word,
  input  logic                    touch,
  input  logic [ADDR_W-1:0]       fill_addr,
  output logic                    fill_way,
  input  logic                    we,
  input  logic                    wr_way,
  input  logic [LINE_BYTES*8-1:0] wr_line
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WORDS  = LINE_BYTES / 4;

  logic [IDX_W-1:0]  l_idx, f_idx;
  logic [TAG_W-1:0]  l_tag, f_tag;
  logic [OFF_W-1:0]  l_off;
  logic [1:0]        way_hit, way_fvalid;
  logic [LINE_W-1:0] way_line [2];
  logic [LINE_W-1:0] hit_line;
  logic [SETS-1:0]   lru_reg;
  logic              unused_fill_off;

  assign l_idx = lookup_addr[OFF_W +: IDX_W];
  assign l_tag = lookup_addr[ADDR_W-1 -: TAG_W];
  assign l_off = lookup_addr[OFF_W-1:0];
  assign f_idx = fill_addr[OFF_W +: IDX_W];
  assign f_tag = fill_addr[ADDR_W-1 -: TAG_W];
  assign unused_fill_off = ^fill_addr[OFF_W-1:0];

  // Always build two way slots; slots beyond WAYS never hit and look
  // permanently valid so the victim logic never picks them.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      if (gi < WAYS) begin : g_used
        logic [TAG_W-1:0]  tag_mem  [SETS];
        logic [LINE_W-1:0] data_mem [SETS];
        logic [SETS-1:0]   valid_reg;

        // Flush takes priority over a simultaneous refill write.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            valid_reg <= '0;
          end else if (en) begin
            if (flush)
              valid_reg <= '0;
            else if (we && (wr_way == 1'(gi)))
              valid_reg[f_idx] <= 1'b1;
          end
        end

        always_ff @(posedge clk) begin
          if (en && we && !flush && (wr_way == 1'(gi))) begin
            tag_mem[f_idx]  <= f_tag;
            data_mem[f_idx] <= wr_line;
          end
        end

        assign way_hit[gi]    = valid_reg[l_idx] && (tag_mem[l_idx] == l_tag);
        assign way_line[gi]   = data_mem[l_idx];
        assign way_fvalid[gi] = valid_reg[f_idx];
      end else begin : g_unused
        assign way_hit[gi]    = 1'b0;
        assign way_line[gi]   = '0;
        assign way_fvalid[gi] = 1'b1;
      end
    end
  endgenerate

  assign hit      = |way_hit;
  assign hit_way  = way_hit[1];
  assign hit_line = way_line[hit_way];

  always_comb begin
    hit_word = ZeroWord;
    for (int w = 0; w < WORDS; w++)
      if ((l_off >> 2) == OFF_W'(w))
        hit_word = hit_line[32*w +: 32];
  end

  // Victim: first invalid way (way 0 first), otherwise the LRU way.
  always_comb begin
    if (WAYS == 1)           fill_way = 1'b0;
    else if (!way_fvalid[0]) fill_way = 1'b0;
    else if (!way_fvalid[1]) fill_way = 1'b1;
    else                     fill_way = lru_reg[f_idx];
  end

  // LRU bit names the way to evict next; any access points it away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru_reg <= '0;
    end else if (en) begin
      if (flush)
        lru_reg <= '0;
      else if (we)
        lru_reg[f_idx] <= ~wr_way;
      else if (touch && hit)
        lru_reg[l_idx] <= ~hit_way;
    end
  end

endmodule

// File: rtl/ifu_assoc.sv
// ifu_assoc
// Instruction fetch unit: next-PC generation, set-associative I-cache
// lookup, whole-line refill from the RAM instruction port, flush and
// IF-stage PC/instruction registers.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rdy               global enable (all registers hold when low)
//   stall             pipeline stall vector, bit 0 freezes IF
//   use_npc,npc_addr  redirect request and target
//   flush             invalidate all cache lines
//   ram_inst,         refill line data (valid as busy falls) and busy flag
//   ram_inst_busy
//   pc, inst          IF-stage PC and instruction (0 = bubble)
//   ram_inst_re,      refill request and line-aligned refill address
//   ram_inst_addr
//   stall_req         held high while a miss is outstanding
//   hit_cnt,miss_cnt  performance counters
// Optional feature macro: IFU_PERF_CNT_EN enables hit_cnt/miss_cnt;
// without it both outputs are constant zero.
module ifu_assoc
  import ifu_assoc_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 32,
  parameter int WAYS       = 2,
  parameter int STALL_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    use_npc,
  input  logic [ADDR_W-1:0]       npc_addr,
  input  logic                    flush,
  input  logic [LINE_BYTES*8-1:0] ram_inst,
  input  logic                    ram_inst_busy,
  output logic [ADDR_W-1:0]       pc,
  output logic [31:0]             inst,
  output logic                    ram_inst_re,
  output logic [31:0]             ram_inst_addr,
  output logic                    stall_req,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int WORDS = LINE_BYTES / 4;

  ifu_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next, npc;
  logic [31:0]       inst_reg, inst_next;
  logic [31:0]       addr_reg, addr_next;
  logic              re_reg, re_next;
  logic              sreq_reg, sreq_next;
  logic              drop_reg, drop_next;
  logic              hit, hit_way, fill_way, arr_we, arr_touch;
  logic [31:0]       hit_word, ram_word;
  logic [OFF_W-1:0]  pc_off;
  logic              unused_stall;

  assign unused_stall = ^stall;
  assign npc    = use_npc ? npc_addr : pc_reg + ADDR_W'(4);
  assign pc_off = pc_reg[OFF_W-1:0];

  icache_sa_array #(
    .ADDR_W    (ADDR_W),
    .LINE_BYTES(LINE_BYTES),
    .SETS      (SETS),
    .WAYS      (WAYS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .en         (rdy),
    .flush      (flush),
    .lookup_addr(npc),
    .hit        (hit),
    .hit_way    (hit_way),
    .hit_word   (hit_word),
    .touch      (arr_touch),
    .fill_addr  (pc_reg),
    .fill_way   (fill_way),
    .we         (arr_we),
    .wr_way     (fill_way),
    .wr_line    (ram_inst)
  );

  // pc_reg already holds the missed address while refilling.
  always_comb begin
    ram_word = ZeroWord;
    for (int w = 0; w < WORDS; w++)
      if ((pc_off >> 2) == OFF_W'(w))
        ram_word = ram_inst[32*w +: 32];
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    addr_next  = addr_reg;
    re_next    = re_reg;
    sreq_next  = sreq_reg;
    drop_next  = drop_reg;
    arr_we     = False_v;
    arr_touch  = False_v;
    if (rdy) begin
      case (state_reg)
        LOOKUP: begin
          drop_next = False_v;
          if (!stall[0]) begin
            pc_next   = npc;
            addr_next = 32'(npc) & ~32'(LINE_BYTES - 1);
            if (hit) begin
              inst_next  = hit_word;
              arr_touch  = True_v;
              state_next = is_branch_load(hit_word) ? BUBBLE : LOOKUP;
            end else begin
              inst_next  = ZeroWord;
              sreq_next  = True_v;
              re_next    = True_v;
              state_next = REQ;
            end
          end
        end
        REQ: begin
          if (flush) drop_next = True_v;
          if (ram_inst_busy) state_next = WAIT;
        end
        WAIT: begin
          if (flush) drop_next = True_v;
          if (!ram_inst_busy) begin
            // A flush seen during this refill (or on this edge) keeps the
            // stale line out of the cache; the instruction still retires.
            arr_we     = !(drop_reg || flush);
            inst_next  = ram_word;
            sreq_next  = False_v;
            re_next    = False_v;
            state_next = is_branch_load(ram_word) ? BUBBLE : LOOKUP;
          end
        end
        BUBBLE: begin
          if (!stall[0]) begin
            inst_next  = ZeroWord;
            state_next = LOOKUP;
          end
        end
        default: state_next = LOOKUP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LOOKUP;
      pc_reg    <= {ADDR_W{1'b1}} - ADDR_W'(3);
      inst_reg  <= ZeroWord;
      addr_reg  <= 32'hFFFF_FFFF;
      re_reg    <= False_v;
      sreq_reg  <= False_v;
      drop_reg  <= False_v;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      addr_reg  <= addr_next;
      re_reg    <= re_next;
      sreq_reg  <= sreq_next;
      drop_reg  <= drop_next;
    end
  end

  assign pc            = pc_reg;
  assign inst          = inst_reg;
  assign ram_inst_re   = re_reg;
  assign ram_inst_addr = addr_reg;
  assign stall_req     = sreq_reg;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;
  logic        hit_take, miss_take;

  assign hit_take  = rdy && (state_reg == LOOKUP) && !stall[0] && hit;
  assign miss_take = rdy && (state_reg == LOOKUP) && !stall[0] && !hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_reg  <= ZeroWord;
      miss_cnt_reg <= ZeroWord;
    end else begin
      if (hit_take)  hit_cnt_reg  <= hit_cnt_reg + 32'd1;
      if (miss_take) miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`else
  assign hit_cnt  = ZeroWord;
  assign miss_cnt = ZeroWord;
`endif

endmodule

// File: tb/tb_ifu_assoc.sv
// tb_ifu_assoc
// Directed bench for ifu_assoc (ADDR_W=17, 16-byte lines, 32 sets, 2 ways).
// A background RAM model raises busy one cycle after a request, holds it
// three cycles and returns a line whose words encode their own address.
module tb_ifu_assoc;

  localparam int ADDR_W     = 17;
  localparam int LINE_BYTES = 16;
  localparam int SETS       = 32;
  localparam int WAYS       = 2;
  localparam int STALL_W    = 5;
`ifdef IFU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst, rdy, use_npc, flush, ram_inst_busy;
  logic [STALL_W-1:0]      stall;
  logic [ADDR_W-1:0]       npc_addr, pc;
  logic [LINE_BYTES*8-1:0] ram_inst;
  logic [31:0]             inst, ram_inst_addr, hit_cnt, miss_cnt;
  logic                    ram_inst_re, stall_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu_assoc #(
    .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .SETS(SETS),
    .WAYS(WAYS), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .use_npc(use_npc),
    .npc_addr(npc_addr), .flush(flush), .ram_inst(ram_inst),
    .ram_inst_busy(ram_inst_busy), .pc(pc), .inst(inst),
    .ram_inst_re(ram_inst_re), .ram_inst_addr(ram_inst_addr),
    .stall_req(stall_req), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Memory image: each word carries its address; 0x8 holds a branch.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] op;
    op = (a[16:0] == 17'h8) ? 8'h63 : 8'h13;
    return {7'h0, a[16:0], op};
  endfunction

  function automatic logic [127:0] make_line(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = {a[31:4], 4'h0};
    for (int i = 0; i < 4; i++) l[32*i +: 32] = word_at(base + 32'(4 * i));
    return l;
  endfunction

  initial begin
    ram_inst_busy = 1'b0;
    ram_inst      = '0;
    forever begin
      @(negedge clk);
      if (ram_inst_re && !ram_inst_busy) begin
        ram_inst_busy = 1'b1;
        repeat (3) @(negedge clk);
        ram_inst      = make_line(ram_inst_addr);
        ram_inst_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_at(input logic [31:0] a, input bit exp_miss, input string name);
    bit missed;
    int n;
    stall    = '0;
    use_npc  = 1'b1;
    npc_addr = a[ADDR_W-1:0];
    tick();
    missed = stall_req;
    n = 0;
    while (stall_req && n < 20) begin
      tick();
      n++;
    end
    check({name, " stall_req released"}, {31'b0, stall_req}, 32'd0);
    stall   = 5'b00001;
    use_npc = 1'b0;
    check({name, " miss"}, {31'b0, missed}, {31'b0, exp_miss});
    check({name, " pc"}, 32'(pc), a);
    check({name, " inst"}, inst, word_at(a));
    $display("fetch %-14s addr=%h missed=%0d pc=%h inst=%h", name, a, missed, pc, inst);
  endtask

  typedef struct {
    logic        s0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        sreq;
    logic        re;
    logic [31:0] addr;
    int          hits;
    int          misses;
  } vec_t;

  function automatic vec_t mk(logic s0, logic [31:0] p, logic [31:0] i, logic sr,
                              logic r, logic [31:0] a, int h, int m);
    vec_t v;
    v.s0 = s0; v.pc = p; v.inst = i; v.sreq = sr; v.re = r;
    v.addr = a; v.hits = h; v.misses = m;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    int n;

    // One row per clock edge after reset release.
    vecs[0]  = mk(0, 32'h0,  32'h0,              1, 1, 32'h0,  0, 1);
    vecs[1]  = mk(0, 32'h0,  32'h0,              1, 1, 32'h0,  0, 1);
    vecs[2]  = mk(0, 32'h0,  32'h0,              1, 1, 32'h0,  0, 1);
    vecs[3]  = mk(0, 32'h0,  32'h0,              1, 1, 32'h0,  0, 1);
    vecs[4]  = mk(0, 32'h0,  word_at(32'h0),     0, 0, 32'h0,  0, 1);
    vecs[5]  = mk(0, 32'h4,  word_at(32'h4),     0, 0, 32'h0,  1, 1);
    vecs[6]  = mk(0, 32'h8,  word_at(32'h8),     0, 0, 32'h0,  2, 1);
    vecs[7]  = mk(1, 32'h8,  word_at(32'h8),     0, 0, 32'h0,  2, 1);
    vecs[8]  = mk(0, 32'h8,  32'h0,              0, 0, 32'h0,  2, 1);
    vecs[9]  = mk(0, 32'hC,  word_at(32'hC),     0, 0, 32'h0,  3, 1);
    vecs[10] = mk(0, 32'h10, 32'h0,              1, 1, 32'h10, 3, 2);
    vecs[11] = mk(0, 32'h10, 32'h0,              1, 1, 32'h10, 3, 2);
    vecs[12] = mk(0, 32'h10, 32'h0,              1, 1, 32'h10, 3, 2);
    vecs[13] = mk(0, 32'h10, 32'h0,              1, 1, 32'h10, 3, 2);
    vecs[14] = mk(0, 32'h10, word_at(32'h10),    0, 0, 32'h10, 3, 2);

    rst = 1'b1; rdy = 1'b1; stall = '0; use_npc = 1'b0;
    npc_addr = '0; flush = 1'b0;
    tick();
    tick();
    check("reset pc", 32'(pc), 32'h1FFFC);
    check("reset inst", inst, 32'h0);
    check("reset re", {31'b0, ram_inst_re}, 32'd0);
    check("reset addr", ram_inst_addr, 32'hFFFF_FFFF);
    check("reset stall_req", {31'b0, stall_req}, 32'd0);
    check("reset hit_cnt", hit_cnt, 32'd0);
    check("reset miss_cnt", miss_cnt, 32'd0);
    $display("reset pc=%h inst=%h addr=%h", pc, inst, ram_inst_addr);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 15; r++) begin
      stall = {4'b0, vecs[r].s0};
      tick();
      check($sformatf("row%0d pc", r), 32'(pc), vecs[r].pc);
      check($sformatf("row%0d inst", r), inst, vecs[r].inst);
      check($sformatf("row%0d stall_req", r), {31'b0, stall_req}, {31'b0, vecs[r].sreq});
      check($sformatf("row%0d re", r), {31'b0, ram_inst_re}, {31'b0, vecs[r].re});
      check($sformatf("row%0d addr", r), ram_inst_addr, vecs[r].addr);
      check($sformatf("row%0d hit_cnt", r), hit_cnt, PERF ? 32'(vecs[r].hits) : 32'd0);
      check($sformatf("row%0d miss_cnt", r), miss_cnt, PERF ? 32'(vecs[r].misses) : 32'd0);
      $display("row %0d pc=%h inst=%h stall_req=%0d re=%0d addr=%h",
               r, pc, inst, stall_req, ram_inst_re, ram_inst_addr);
    end

    // LRU replacement within set 0.
    fetch_at(32'h0000, 0, "lru a0");
    fetch_at(32'h0200, 1, "lru b0");
    fetch_at(32'h0000, 0, "lru a1");
    fetch_at(32'h0400, 1, "lru c0");
    fetch_at(32'h0000, 0, "lru a2");
    fetch_at(32'h0200, 1, "lru b1");
    fetch_at(32'h0000, 0, "lru a3");

    // Flush during WAIT: instruction delivered, line dropped, cache empty.
    stall = '0; use_npc = 1'b1; npc_addr = 17'h1000;
    tick();
    check("flush miss stall_req", {31'b0, stall_req}, 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (stall_req && n < 20) begin
      tick();
      n++;
    end
    check("flush stall_req released", {31'b0, stall_req}, 32'd0);
    stall = 5'b00001; use_npc = 1'b0;
    check("flush pc", 32'(pc), 32'h1000);
    check("flush inst", inst, word_at(32'h1000));
    $display("flush refill pc=%h inst=%h", pc, inst);
    fetch_at(32'h1000, 1, "refetch");
    fetch_at(32'h0000, 1, "post-flush a");
    fetch_at(32'h0010, 1, "post-flush b");
    fetch_at(32'h1000, 0, "refetch hit");

    // stall[0] in LOOKUP holds pc/inst even with a redirect pending.
    use_npc = 1'b1; npc_addr = 17'h0100; stall = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall%0d pc", k), 32'(pc), 32'h1000);
      check($sformatf("stall%0d inst", k), inst, word_at(32'h1000));
      $display("stall cycle %0d pc=%h inst=%h", k, pc, inst);
    end
    stall = '0;
    tick();
    check("release pc", 32'(pc), 32'h0100);
    n = 0;
    while (stall_req && n < 20) begin
      tick();
      n++;
    end
    stall = 5'b00001; use_npc = 1'b0;
    check("release inst", inst, word_at(32'h0100));
    $display("release pc=%h inst=%h", pc, inst);

    // Asynchronous reset in the middle of a refill.
    stall = '0; use_npc = 1'b1; npc_addr = 17'h0800;
    tick();
    tick();
    check("pre-reset re", {31'b0, ram_inst_re}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst re", {31'b0, ram_inst_re}, 32'd0);
    check("async rst stall_req", {31'b0, stall_req}, 32'd0);
    check("async rst hit_cnt", hit_cnt, 32'd0);
    check("async rst miss_cnt", miss_cnt, 32'd0);
    check("async rst pc", 32'(pc), 32'h1FFFC);
    check("async rst inst", inst, 32'h0);
    check("async rst addr", ram_inst_addr, 32'hFFFF_FFFF);
    $display("async reset re=%0d stall_req=%0d pc=%h", ram_inst_re, stall_req, pc);
    stall = 5'b00001; use_npc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) tick();
    fetch_at(32'h0000, 1, "post-reset");
    check("post-reset miss_cnt", miss_cnt, PERF ? 32'd1 : 32'd0);
    check("post-reset hit_cnt", hit_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
